// File: rtl/seven_seg_display_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_pkg
// Brief   : Shared encodings and constants for the 7-segment display scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam int          DIGIT_W    = 7;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [7:0]  AN_ALL_OFF = 8'hFF;

    typedef enum logic [1:0] {
        SRC_NUM1   = 2'd0,
        SRC_NUM2   = 2'd1,
        SRC_ANSWER = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        SHOW_NUM1   = 2'd0,
        SHOW_NUM2   = 2'd1,
        SHOW_ANSWER = 2'd2
    } state_t;

    function automatic state_t advance_state(input state_t s);
        case (s)
            SHOW_NUM1: advance_state = SHOW_NUM2;
            SHOW_NUM2: advance_state = SHOW_ANSWER;
            default:   advance_state = SHOW_NUM1;
        endcase
    endfunction

    function automatic src_t state_to_src(input state_t s);
        case (s)
            SHOW_NUM2:   state_to_src = SRC_NUM2;
            SHOW_ANSWER: state_to_src = SRC_ANSWER;
            default:     state_to_src = SRC_NUM1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_display_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_display_scheduler_if
// Brief   : Datapath/decoder/board signals around the display scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface seven_seg_display_scheduler_if;
    import seven_seg_pkg::*;

    logic [15:0]                   num1;
    logic [15:0]                   num2;
    logic [31:0]                   answer;
    logic                          answer_valid;
    logic                          next_btn;
    logic [31:0]                   binary_number;
    logic [NUM_DIGITS*DIGIT_W-1:0] digit_patterns;
    logic [DIGIT_W-1:0]            seg_out;
    logic [NUM_DIGITS-1:0]         an_out;
    logic [1:0]                    src_sel;

    modport master (
        output num1, num2, answer, answer_valid, next_btn, digit_patterns,
        input  binary_number, seg_out, an_out, src_sel
    );

    modport slave (
        input  num1, num2, answer, answer_valid, next_btn, digit_patterns,
        output binary_number, seg_out, an_out, src_sel
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_display_scheduler_refresh_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : refresh_tick_gen
// Brief   : Free-running 0..CLK_DIV-1 counter; tick marks the last count.
// Revision: 1.0 - initial release
// ============================================================================
module refresh_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  wire logic clk,
    input  wire logic reset,
    output logic      tick
);
    localparam int             CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/seven_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_display_scheduler
// Brief   : Source select, digit scan and ghost-free switching for an 8-digit
//           7-segment display. Optional AUTO_CYCLE_EN rotates sources by frame.
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_display_scheduler
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = seven_seg_pkg::NUM_DIGITS
`ifdef AUTO_CYCLE_EN
    ,
    parameter int FRAMES_PER_ROTATE = 200
`endif
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    seven_seg_display_scheduler_if.slave bus
);
    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                                    tick;
    logic [IDX_W-1:0]                        idx;
    logic [IDX_W-1:0]                        idx_next;
    logic                                    frame_end;
    logic                                    auto_adv;
    logic                                    src_change;
    logic                                    blank_pending;
    state_t                                  state;
    state_t                                  state_next;
    logic [1:0]                              src_sel;
    logic [DIGIT_W-1:0]                      seg;
    logic [NUM_DIGITS-1:0]                   an;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      pats;
    logic [31:0]                             bin;

    refresh_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign pats      = bus.digit_patterns;
    assign idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign frame_end = tick && (idx == IDX_LAST);

`ifdef AUTO_CYCLE_EN
    localparam int FW = (FRAMES_PER_ROTATE > 1) ? $clog2(FRAMES_PER_ROTATE) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_ROTATE - 1);

    logic [FW-1:0] frame_cnt;

    assign auto_adv = frame_end && (frame_cnt == FRAME_LAST);

    // Also cleared on auto_adv so an absorbed rotation (answer_valid already
    // showing ANSWER) restarts the count instead of running past the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (src_change || auto_adv) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`else
    assign auto_adv = 1'b0;
`endif

    // answer_valid outranks both the button and the auto rotation.
    always_comb begin
        state_next = state;
        if (bus.answer_valid) begin
            state_next = SHOW_ANSWER;
        end else if (bus.next_btn || auto_adv) begin
            state_next = advance_state(state);
        end
    end

    assign src_change = (state_next != state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SHOW_NUM1;
            src_sel       <= SRC_NUM1;
            idx           <= '0;
            seg           <= SEG_BLANK;
            an            <= AN_ALL_OFF;
            blank_pending <= 1'b0;
        end else begin
            state   <= state_next;
            src_sel <= state_to_src(state_next);
            if (tick) begin
                idx <= idx_next;
                if (blank_pending) begin
                    seg <= SEG_BLANK;
                    an  <= AN_ALL_OFF;
                end else begin
                    seg <= pats[idx_next];
                    an  <= ~(NUM_DIGITS'(1) << idx_next);
                end
            end
            // A change re-arms even while a blank slot is being consumed.
            if (src_change) begin
                blank_pending <= 1'b1;
            end else if (tick) begin
                blank_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        bin = 32'h0;
        case (src_sel)
            SRC_NUM1:   bin = {16'h0, bus.num1};
            SRC_NUM2:   bin = {16'h0, bus.num2};
            SRC_ANSWER: bin = bus.answer;
            default:    bin = 32'h0;
        endcase
    end

    assign bus.binary_number = bin;
    assign bus.seg_out       = seg;
    assign bus.an_out        = an;
    assign bus.src_sel       = src_sel;
endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_display_scheduler
// Brief   : Random and directed stimulus against a slot-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seven_seg_display_scheduler;
    localparam int CLK_DIV = 4;
    localparam int FRAMES  = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    seven_seg_display_scheduler_if ifc();

    seven_seg_display_scheduler #(
        .CLK_DIV(CLK_DIV)
`ifdef AUTO_CYCLE_EN
        , .FRAMES_PER_ROTATE(FRAMES)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: active-low hex digits with leading-zero blanking.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
            4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
        endcase
        return ~p;
    endfunction

    function automatic logic [55:0] decode(input logic [31:0] v);
        logic [55:0] r;
        int          top;
        top = 0;
        for (int k = 0; k < 8; k++) if (v[4*k +: 4] != 4'h0) top = k;
        for (int k = 0; k < 8; k++) r[7*k +: 7] = (k <= top) ? hex7(v[4*k +: 4]) : 7'h7F;
        return r;
    endfunction

    assign ifc.digit_patterns = decode(ifc.binary_number);

    // Reference model state
    int         m_cyc, m_ticks, m_src, m_frames;
    bit         m_blank;
    logic [6:0] m_seg;
    logic [7:0] m_an;

    function automatic logic [31:0] model_bin(input int s);
        case (s)
            0:       return {16'h0, ifc.num1};
            1:       return {16'h0, ifc.num2};
            default: return ifc.answer;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst_v, input bit av, input bit nb);
        logic [55:0] pats;
        bit          tick, frame_end, auto;
        int          k, nsrc;
        reset            = rst_v;
        ifc.answer_valid = av;
        ifc.next_btn     = nb;
        pats = decode(model_bin(m_src));
        @(posedge clk);
        if (rst_v) begin
            m_cyc = 0; m_ticks = 0; m_src = 0; m_frames = 0;
            m_blank = 0; m_seg = 7'h7F; m_an = 8'hFF;
        end else begin
            tick = (m_cyc % CLK_DIV) == (CLK_DIV - 1);
            m_cyc++;
            frame_end = 0;
            auto = 0;
            if (tick) begin
                m_ticks++;
                k = m_ticks % 8;
                frame_end = (k == 0);
                if (m_blank) begin
                    m_seg = 7'h7F; m_an = 8'hFF;
                end else begin
                    m_seg = pats[7*k +: 7];
                    m_an  = 8'hFF ^ (8'h01 << k);
                end
            end
`ifdef AUTO_CYCLE_EN
            if (frame_end) begin
                m_frames++;
                if (m_frames == FRAMES) auto = 1;
            end
`endif
            nsrc = av ? 2 : ((nb || auto) ? (m_src + 1) % 3 : m_src);
            if (nsrc != m_src || auto) m_frames = 0;
            if (nsrc != m_src) m_blank = 1;
            else if (tick) m_blank = 0;
            m_src = nsrc;
        end
        #1;
        check("seg_out", 32'(ifc.seg_out), 32'(m_seg));
        check("an_out", 32'(ifc.an_out), 32'(m_an));
        check("src_sel", 32'(ifc.src_sel), 32'(m_src));
        check("binary_number", ifc.binary_number, model_bin(m_src));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        ifc.num1 = 16'h00A5;
        ifc.num2 = 16'h1234;
        ifc.answer = 32'hDEADBEEF;
        ifc.answer_valid = 1'b0;
        ifc.next_btn = 1'b0;
        #2;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("reset_seg", 32'(ifc.seg_out), 32'h7F);
        check("reset_an", 32'(ifc.an_out), 32'hFF);
        check("reset_src", 32'(ifc.src_sel), 32'd0);
        check("reset_bin", ifc.binary_number, 32'h000000A5);

        // Two full frames of NUM1 scanning
        run(70);

        step(1'b0, 1'b0, 1'b1);
        check("btn_src", 32'(ifc.src_sel), 32'd1);
        check("btn_bin", ifc.binary_number, 32'h00001234);
        run(40);

        step(1'b0, 1'b1, 1'b1);
        check("prio_src", 32'(ifc.src_sel), 32'd2);
        check("prio_bin", ifc.binary_number, 32'hDEADBEEF);
        run(20);

        step(1'b0, 1'b1, 1'b0);
        check("av_in_answer_src", 32'(ifc.src_sel), 32'd2);
        run(20);

        // Abort mid-frame once the scan sits on digit 5
        for (int i = 0; i < 64 && (m_ticks % 8) != 5; i++) step(1'b0, 1'b0, 1'b0);
        check("reach_idx5", 32'(m_ticks % 8), 32'd5);
        step(1'b1, 1'b0, 1'b0);
        check("midreset_seg", 32'(ifc.seg_out), 32'h7F);
        check("midreset_an", 32'(ifc.an_out), 32'hFF);
        check("midreset_src", 32'(ifc.src_sel), 32'd0);
        run(CLK_DIV);
        check("restart_an", 32'(ifc.an_out), 32'hFD);

`ifdef AUTO_CYCLE_EN
        run(200);
`endif

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) ifc.num1 = 16'($urandom);
            if ($urandom_range(0, 49) == 0) ifc.num2 = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) ifc.answer = $urandom;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
